// File: rtl/keypad_apb_pkg.sv
// Shared definitions for the keypad APB register block.
// Holds the register map, interrupt bit layout, the CONTROL soft-clear bit,
// the empty-FIFO read value and the access state type.
package keypad_apb_pkg;

  localparam logic [31:0] OFF_CLK_DIV     = 32'h00;
  localparam logic [31:0] OFF_DEBOUNCE    = 32'h04;
  localparam logic [31:0] OFF_TIMEOUT     = 32'h08;
  localparam logic [31:0] OFF_FIFO_STATUS = 32'h0C;
  localparam logic [31:0] OFF_INTR_STATUS = 32'h10;
  localparam logic [31:0] OFF_INTR_EN     = 32'h14;
  localparam logic [31:0] OFF_CONTROL     = 32'h18;
  localparam logic [31:0] CH_DATA_BASE    = 32'h20;
  localparam logic [31:0] CH_DATA_STRIDE  = 32'h04;

  localparam int unsigned INTR_EV_BASE = 0;
  localparam int unsigned INTR_OV_BASE = 8;
  localparam int unsigned CTRL_CLR_BIT = 0;

  // Returned by a CH_DATA read while that FIFO is empty.
  localparam logic [31:0] CH_EMPTY_RDATA = 32'h8000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  function automatic logic [31:0] ch_data_addr(input int unsigned idx);
    return CH_DATA_BASE + CH_DATA_STRIDE * idx;
  endfunction

endpackage

// File: rtl/keypad_intr_ctrl.sv
// Interrupt aggregation for the keypad channels.
// Ports:
//   pclk, preset     clock, synchronous active-high reset
//   key_event        per-channel one-cycle key pulses
//   fifo_full        per-channel FIFO full flags (key while full = overflow)
//   status_we        W1C write strobe for INTR_STATUS (uses wdata)
//   en_we            write strobe for INTR_EN (uses wdata)
//   soft_clr         clear every status bit
//   wdata            APB write data
//   status, enable   register images in the 32-bit INTR layout
//   irq              registered |(status & enable)
module keypad_intr_ctrl
  import keypad_apb_pkg::*;
#(
  parameter int unsigned NUM_CH = 2
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [NUM_CH-1:0] key_event,
  input  logic [NUM_CH-1:0] fifo_full,
  input  logic              status_we,
  input  logic              en_we,
  input  logic              soft_clr,
  input  logic [31:0]       wdata,
  output logic [31:0]       status,
  output logic [31:0]       enable,
  output logic              irq
);

  logic [NUM_CH-1:0] ev_sts, ov_sts, ev_en, ov_en;
  logic [NUM_CH-1:0] ev_clr, ov_clr;

  always_comb begin
    ev_clr = '0;
    ov_clr = '0;
    if (status_we) begin
      ev_clr = wdata[INTR_EV_BASE +: NUM_CH];
      ov_clr = wdata[INTR_OV_BASE +: NUM_CH];
    end
    if (soft_clr) begin
      ev_clr = '1;
      ov_clr = '1;
    end
  end

  // Clear is applied before set, so a new event in the clearing cycle survives.
  always_ff @(posedge pclk) begin
    if (preset) begin
      ev_sts <= '0;
      ov_sts <= '0;
      ev_en  <= '0;
      ov_en  <= '0;
      irq    <= 1'b0;
    end else begin
      ev_sts <= (ev_sts & ~ev_clr) | key_event;
      ov_sts <= (ov_sts & ~ov_clr) | (key_event & fifo_full);
      if (en_we) begin
        ev_en <= wdata[INTR_EV_BASE +: NUM_CH];
        ov_en <= wdata[INTR_OV_BASE +: NUM_CH];
      end
      irq <= |((ev_sts & ev_en) | (ov_sts & ov_en));
    end
  end

  always_comb begin
    status = '0;
    enable = '0;
    status[INTR_EV_BASE +: NUM_CH] = ev_sts;
    status[INTR_OV_BASE +: NUM_CH] = ov_sts;
    enable[INTR_EV_BASE +: NUM_CH] = ev_en;
    enable[INTR_OV_BASE +: NUM_CH] = ov_en;
  end

endmodule

// File: rtl/apb_keypad_regs.sv
// APB register block for the multi-channel keypad subsystem.
// Every access takes one wait state: the access cycle decodes, performs the
// write or side effect and registers prdata; the following RESP cycle drives
// pready, pslverr and any FIFO pop strobe.
// Ports:
//   pclk, preset                 clock, synchronous active-high reset
//   psel, penable, pwrite,
//   paddr, pwdata                APB request
//   prdata, pready, pslverr      APB response (prdata registered)
//   clk_divider_limit_o,
//   debounce_limit_o,
//   scan_timeout_limit_o         configuration outputs
//   cfg_update_o                 one-cycle pulse after a config write
//   fifo_empty_i, fifo_full_i,
//   fifo_data_i                  per-channel FIFO status and head data
//   fifo_rd_en_o                 per-channel pop strobes
//   key_event_i                  per-channel key pulses
//   irq_o                        registered interrupt
module apb_keypad_regs
  import keypad_apb_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CLK_DIV_W  = 20,
  parameter int unsigned DEBOUNCE_W = 8,
  parameter int unsigned TIMEOUT_W  = 4,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDR_W-1:0]        paddr,
  input  logic [31:0]              pwdata,
  output logic [31:0]              prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [CLK_DIV_W-1:0]     clk_divider_limit_o,
  output logic [DEBOUNCE_W-1:0]    debounce_limit_o,
  output logic [TIMEOUT_W-1:0]     scan_timeout_limit_o,
  output logic                     cfg_update_o,
  input  logic [NUM_CH-1:0]        fifo_empty_i,
  input  logic [NUM_CH-1:0]        fifo_full_i,
  input  logic [NUM_CH*DATA_W-1:0] fifo_data_i,
  output logic [NUM_CH-1:0]        fifo_rd_en_o,
  input  logic [NUM_CH-1:0]        key_event_i,
  output logic                     irq_o
);

  state_t            state;
  logic              access;
  logic [31:0]       addr;
  logic              sel_clk, sel_deb, sel_tmo, sel_fsts, sel_ists, sel_ien, sel_ctrl;
  logic [NUM_CH-1:0] ch_hit;
  logic              mapped, err, wr_ok, rd_ok;
  logic [31:0]       rd_val;
  logic [31:0]       fifo_status;
  logic [31:0]       intr_status, intr_enable;
  logic [DATA_W-1:0] ch_data [NUM_CH];

  assign access = (state == IDLE) && psel && penable;
  assign addr   = 32'(paddr);
  assign pready = (state == RESP);

  assign sel_clk  = (addr == OFF_CLK_DIV);
  assign sel_deb  = (addr == OFF_DEBOUNCE);
  assign sel_tmo  = (addr == OFF_TIMEOUT);
  assign sel_fsts = (addr == OFF_FIFO_STATUS);
  assign sel_ists = (addr == OFF_INTR_STATUS);
  assign sel_ien  = (addr == OFF_INTR_EN);
  assign sel_ctrl = (addr == OFF_CONTROL);

  always_comb begin
    ch_hit      = '0;
    fifo_status = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_hit[i]          = (addr == ch_data_addr(i));
      fifo_status[2*i]   = fifo_empty_i[i];
      fifo_status[2*i+1] = fifo_full_i[i];
      ch_data[i]         = fifo_data_i[i*DATA_W +: DATA_W];
    end
  end

  // Full-address compares also reject misaligned and out-of-range channel
  // addresses, since none of them can match a decoded location.
  assign mapped = sel_clk | sel_deb | sel_tmo | sel_fsts | sel_ists |
                  sel_ien | sel_ctrl | (|ch_hit);
  assign err    = !mapped || (paddr[1:0] != 2'b00) ||
                  (pwrite && (sel_fsts || (|ch_hit)));
  assign wr_ok  = access && !err && pwrite;
  assign rd_ok  = access && !err && !pwrite;

  always_comb begin
    rd_val = '0;
    if (sel_clk)  rd_val = 32'(clk_divider_limit_o);
    if (sel_deb)  rd_val = 32'(debounce_limit_o);
    if (sel_tmo)  rd_val = 32'(scan_timeout_limit_o);
    if (sel_fsts) rd_val = fifo_status;
    if (sel_ists) rd_val = intr_status;
    if (sel_ien)  rd_val = intr_enable;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_hit[i]) rd_val = fifo_empty_i[i] ? CH_EMPTY_RDATA : 32'(ch_data[i]);
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state                <= IDLE;
      prdata               <= '0;
      pslverr              <= 1'b0;
      fifo_rd_en_o         <= '0;
      cfg_update_o         <= 1'b0;
      clk_divider_limit_o  <= '0;
      debounce_limit_o     <= '0;
      scan_timeout_limit_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            state        <= RESP;
            prdata       <= rd_ok ? rd_val : '0;
            pslverr      <= err;
            fifo_rd_en_o <= rd_ok ? (ch_hit & ~fifo_empty_i) : '0;
            cfg_update_o <= wr_ok && (sel_clk || sel_deb || sel_tmo);
          end
        end
        RESP: begin
          state        <= IDLE;
          pslverr      <= 1'b0;
          fifo_rd_en_o <= '0;
          cfg_update_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (wr_ok && sel_clk) clk_divider_limit_o  <= pwdata[CLK_DIV_W-1:0];
      if (wr_ok && sel_deb) debounce_limit_o     <= pwdata[DEBOUNCE_W-1:0];
      if (wr_ok && sel_tmo) scan_timeout_limit_o <= pwdata[TIMEOUT_W-1:0];
    end
  end

  keypad_intr_ctrl #(
    .NUM_CH(NUM_CH)
  ) u_intr (
    .pclk      (pclk),
    .preset    (preset),
    .key_event (key_event_i),
    .fifo_full (fifo_full_i),
    .status_we (wr_ok && sel_ists),
    .en_we     (wr_ok && sel_ien),
    .soft_clr  (wr_ok && sel_ctrl && pwdata[CTRL_CLR_BIT]),
    .wdata     (pwdata),
    .status    (intr_status),
    .enable    (intr_enable),
    .irq       (irq_o)
  );

endmodule

// File: tb/tb_apb_keypad_regs.sv
module tb_apb_keypad_regs;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DATA_W = 8;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [19:0] clk_div;
  logic [7:0]  debounce;
  logic [3:0]  timeout;
  logic        cfg_update;
  logic [1:0]  fifo_empty, fifo_full, fifo_rd_en, key_event;
  logic [15:0] fifo_data;
  logic        irq;

  // environment FIFO model: one entry per channel
  logic [1:0]  fifo_valid = 2'b00;
  logic [7:0]  head0 = '0, head1 = '0;
  logic        load = 1'b0;
  logic [1:0]  full_drv = 2'b00;

  assign fifo_empty = ~fifo_valid;
  assign fifo_full  = full_drv;
  assign fifo_data  = {head1, head0};

  always #5 pclk = ~pclk;

  apb_keypad_regs #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CLK_DIV_W(20),
    .DEBOUNCE_W(8), .TIMEOUT_W(4), .ADDR_W(8)
  ) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr),
    .clk_divider_limit_o(clk_div), .debounce_limit_o(debounce),
    .scan_timeout_limit_o(timeout), .cfg_update_o(cfg_update),
    .fifo_empty_i(fifo_empty), .fifo_full_i(fifo_full),
    .fifo_data_i(fifo_data), .fifo_rd_en_o(fifo_rd_en),
    .key_event_i(key_event), .irq_o(irq)
  );

  always @(posedge pclk) begin
    if (load) begin
      fifo_valid <= 2'b11;
      head0 <= 8'h11;
      head1 <= 8'h3A;
    end else begin
      if (fifo_rd_en[0]) fifo_valid[0] <= 1'b0;
      if (fifo_rd_en[1]) fifo_valid[1] <= 1'b0;
    end
  end

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  typedef struct {
    string       name;
    logic        is_rd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // pulse counters and snapshot of the RESP cycle
  int          cfg_pulses = 0;
  int          pop_pulses = 0;
  logic [1:0]  resp_rd_en = '0;
  logic        resp_cfg = 1'b0;
  logic [19:0] resp_clk_div = '0;

  always @(negedge pclk) begin
    if (cfg_update) cfg_pulses++;
    if (fifo_rd_en != 2'b00) pop_pulses++;
  end

  // monitor: compares every response the DUT presents
  always @(negedge pclk) begin
    if (pready) begin
      resp_rd_en   = fifo_rd_en;
      resp_cfg     = cfg_update;
      resp_clk_div = clk_div;
      if (exp_q.size() == 0) begin
        check("unexpected_pready", 32'(pready), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_pslverr"}, 32'(pslverr), 32'(e.err));
        if (e.is_rd) check({e.name, "_prdata"}, prdata, e.rdata);
      end
    end
  end

  task automatic apb(input string name, input logic wr, input logic [7:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_err, input logic [1:0] key_in_wait);
    exp_t e;
    int n;
    e.name = name; e.is_rd = !wr && !exp_err; e.rdata = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge pclk); #1;
    penable = 1'b1;
    key_event = key_in_wait;
    n = 0;
    do begin
      @(posedge pclk); #1;
      key_event = 2'b00;
      n++;
    end while (!pready && n < 4);
    check({name, "_latency"}, 32'(n), 32'd1);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  int c0, p0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    key_event = 2'b00;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_prdata", prdata, 32'h0);
    check("rst_pready", 32'(pready), 32'h0);
    check("rst_pslverr", 32'(pslverr), 32'h0);
    check("rst_clkdiv", 32'(clk_div), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'h0);
    check("rst_cfg_update", 32'(cfg_update), 32'h0);
    load = 1'b1;
    @(posedge pclk); #1;
    load = 1'b0;
    preset = 1'b0;

    // reset-state reads (both FIFOs non-empty, not full)
    apb("rd00", 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 2'b00);
    apb("rd04", 1'b0, 8'h04, 32'h0, 32'h0, 1'b0, 2'b00);
    apb("rd08", 1'b0, 8'h08, 32'h0, 32'h0, 1'b0, 2'b00);
    apb("rd0C", 1'b0, 8'h0C, 32'h0, 32'h0, 1'b0, 2'b00);
    apb("rd10", 1'b0, 8'h10, 32'h0, 32'h0, 1'b0, 2'b00);
    apb("rd14", 1'b0, 8'h14, 32'h0, 32'h0, 1'b0, 2'b00);

    // config writes truncate to the field width
    c0 = cfg_pulses;
    apb("wr_clkdiv", 1'b1, 8'h00, 32'hFFF1_2345, 32'h0, 1'b0, 2'b00);
    check("clkdiv_in_resp", 32'(resp_clk_div), 32'h12345);
    check("cfg_update_in_resp", 32'(resp_cfg), 32'h1);
    check("cfg_update_pulses", 32'(cfg_pulses - c0), 32'd1);
    apb("rb_clkdiv", 1'b0, 8'h00, 32'h0, 32'h0001_2345, 1'b0, 2'b00);
    apb("wr_deb", 1'b1, 8'h04, 32'h5A5A_A5AB, 32'h0, 1'b0, 2'b00);
    check("debounce_out", 32'(debounce), 32'hAB);
    apb("wr_tmo", 1'b1, 8'h08, 32'h0000_001F, 32'h0, 1'b0, 2'b00);
    apb("rb_tmo", 1'b0, 8'h08, 32'h0, 32'h0000_000F, 1'b0, 2'b00);
    check("timeout_out", 32'(timeout), 32'hF);

    // pop-on-read of channel 1, then the empty read
    p0 = pop_pulses;
    apb("rd_ch1", 1'b0, 8'h24, 32'h0, 32'h0000_003A, 1'b0, 2'b00);
    check("ch1_rd_en_resp", 32'(resp_rd_en), 32'h2);
    check("ch1_pop_pulses", 32'(pop_pulses - p0), 32'd1);
    p0 = pop_pulses;
    apb("rd_ch1_empty", 1'b0, 8'h24, 32'h0, 32'h8000_0000, 1'b0, 2'b00);
    check("ch1_empty_no_pop", 32'(pop_pulses - p0), 32'd0);
    apb("rd_fsts", 1'b0, 8'h0C, 32'h0, 32'h0000_0004, 1'b0, 2'b00);

    // interrupts: event + overflow, irq two edges after the pulse
    apb("wr_ien", 1'b1, 8'h14, 32'hFFFF_0101, 32'h0, 1'b0, 2'b00);
    apb("rb_ien", 1'b0, 8'h14, 32'h0, 32'h0000_0101, 1'b0, 2'b00);
    full_drv = 2'b01;
    @(posedge pclk); #1;
    key_event = 2'b01;
    @(posedge pclk); #1;
    key_event = 2'b00;
    check("irq_edge1", 32'(irq), 32'h0);
    @(posedge pclk); #1;
    check("irq_edge2", 32'(irq), 32'h1);
    full_drv = 2'b00;
    apb("rd_ists", 1'b0, 8'h10, 32'h0, 32'h0000_0101, 1'b0, 2'b00);
    apb("fsts_full", 1'b0, 8'h0C, 32'h0, 32'h0000_0004, 1'b0, 2'b00);
    apb("w1c_vs_set", 1'b1, 8'h10, 32'h0000_0001, 32'h0, 1'b0, 2'b01);
    apb("rd_ists_keep", 1'b0, 8'h10, 32'h0, 32'h0000_0101, 1'b0, 2'b00);
    apb("w1c_ov", 1'b1, 8'h10, 32'h0000_0100, 32'h0, 1'b0, 2'b00);
    apb("rd_ists_ev", 1'b0, 8'h10, 32'h0, 32'h0000_0001, 1'b0, 2'b00);
    apb("soft_clr", 1'b1, 8'h18, 32'h0000_0001, 32'h0, 1'b0, 2'b00);
    apb("rd_ists_clr", 1'b0, 8'h10, 32'h0, 32'h0, 1'b0, 2'b00);
    apb("rd_ctrl", 1'b0, 8'h18, 32'h0, 32'h0, 1'b0, 2'b00);
    check("irq_cleared", 32'(irq), 32'h0);

    // error responses without side effects
    p0 = pop_pulses;
    c0 = cfg_pulses;
    apb("err_wr_fsts", 1'b1, 8'h0C, 32'hFFFF_FFFF, 32'h0, 1'b1, 2'b00);
    apb("err_ch2", 1'b0, 8'h28, 32'h0, 32'h0, 1'b1, 2'b00);
    apb("err_misalign", 1'b0, 8'h02, 32'h0, 32'h0, 1'b1, 2'b00);
    apb("err_unmapped", 1'b0, 8'h1C, 32'h0, 32'h0, 1'b1, 2'b00);
    apb("err_wr_ch0", 1'b1, 8'h20, 32'h0, 32'h0, 1'b1, 2'b00);
    apb("err_wr_misalign", 1'b1, 8'h01, 32'h0000_0007, 32'h0, 1'b1, 2'b00);
    check("err_no_pop", 32'(pop_pulses - p0), 32'd0);
    check("err_no_cfg", 32'(cfg_pulses - c0), 32'd0);
    apb("rb_clkdiv_kept", 1'b0, 8'h00, 32'h0, 32'h0001_2345, 1'b0, 2'b00);

    // reset during the wait cycle of a CH_DATA read
    p0 = pop_pulses;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h20;
    @(posedge pclk); #1;
    penable = 1'b1;
    preset = 1'b1;
    @(posedge pclk); #1;
    check("midrst_pready", 32'(pready), 32'h0);
    check("midrst_rd_en", 32'(fifo_rd_en), 32'h0);
    check("midrst_clkdiv", 32'(clk_div), 32'h0);
    check("midrst_debounce", 32'(debounce), 32'h0);
    check("midrst_prdata", prdata, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    check("midrst_no_pop", 32'(pop_pulses - p0), 32'd0);
    apb("rd_ch0_after_rst", 1'b0, 8'h20, 32'h0, 32'h0000_0011, 1'b0, 2'b00);
    check("ch0_rd_en_resp", 32'(resp_rd_en), 32'h1);

    repeat (3) @(posedge pclk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
